alu_core: RTL and testbench

- 8-bit ALU stage directly upstream of the accumulator register; drives the accumulator's data input and load strobe.
- Takes the current accumulator value (a_in) and a memory/operand byte (b_in), executes one operation per start request.
- Single-cycle ops: add, sub, logic, pass.
- Multi-cycle ops: sequential shift-left and shift-add multiply.
- Presents the result with a one-cycle load pulse and registered zero/carry flags.

---
 rtl/alu_core.sv | 160 ++++++++++++++++
 tb/tb_alu_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// 8-bit ALU stage that feeds the accumulator: single-cycle add/sub/logic/pass,
// plus sequential shift-left and shift-add multiply, with a one-cycle load strobe.
module alu_core #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             ld_ac,
  output logic             busy,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only while busy is low (IDLE); every accepted
  // start produces exactly one ld_ac pulse, and result/flags change only with it.
  // A start coinciding with ld_ac is accepted, so single-cycle ops can stream.

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MUL = 2'd2} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sh_val, sh_n;
  logic [2*WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [CNTW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0]   result_n;
  logic               ld_n, zero_n, carry_n;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod_add;

  // Bit WIDTH of the difference is the borrow for unsigned subtraction.
  assign sum      = {1'b0, a_in} + {1'b0, b_in};
  assign diff     = {1'b0, a_in} - {1'b0, b_in};
  assign prod_add = prod + (mplier[0] ? mcand : '0);

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sh_val     <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      cnt        <= '0;
      result     <= '0;
      ld_ac      <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      state      <= state_n;
      sh_val     <= sh_n;
      mcand      <= mcand_n;
      mplier     <= mplier_n;
      prod       <= prod_n;
      cnt        <= cnt_n;
      result     <= result_n;
      ld_ac      <= ld_n;
      zero_flag  <= zero_n;
      carry_flag <= carry_n;
    end
  end

  always_comb begin
    state_n  = state;
    sh_n     = sh_val;
    mcand_n  = mcand;
    mplier_n = mplier;
    prod_n   = prod;
    cnt_n    = cnt;
    result_n = result;
    ld_n     = 1'b0;
    zero_n   = zero_flag;
    carry_n  = carry_flag;

    case (state)
      S_IDLE: begin
        if (start) begin
          ld_n    = 1'b1;
          carry_n = 1'b0;
          case (opcode)
            OP_PASS: result_n = b_in;
            OP_ADD: begin
              result_n = sum[WIDTH-1:0];
              carry_n  = sum[WIDTH];
            end
            OP_SUB: begin
              result_n = diff[WIDTH-1:0];
              carry_n  = diff[WIDTH];
            end
            OP_AND: result_n = a_in & b_in;
            OP_XOR: result_n = a_in ^ b_in;
            OP_SHL: begin
              if (b_in[2:0] == 3'd0) begin
                result_n = a_in;
              end else begin
                ld_n    = 1'b0;
                sh_n    = a_in;
                cnt_n   = CNTW'(b_in[2:0]);
                state_n = S_SHIFT;
              end
            end
            OP_MUL: begin
              ld_n     = 1'b0;
              mcand_n  = {{WIDTH{1'b0}}, a_in};
              mplier_n = b_in;
              prod_n   = '0;
              cnt_n    = CNTW'(WIDTH);
              state_n  = S_MUL;
            end
            default: result_n = a_in;
          endcase
        end
      end
      S_SHIFT: begin
        sh_n  = {sh_val[WIDTH-2:0], 1'b0};
        cnt_n = cnt - 1'b1;
        if (cnt == CNTW'(1)) begin
          result_n = {sh_val[WIDTH-2:0], 1'b0};
          carry_n  = sh_val[WIDTH-1];
          ld_n     = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_MUL: begin
        prod_n   = prod_add;
        mplier_n = mplier >> 1;
        mcand_n  = mcand << 1;
        cnt_n    = cnt - 1'b1;
        if (cnt == CNTW'(1)) begin
          result_n = prod_add[WIDTH-1:0];
          carry_n  = |prod_add[2*WIDTH-1:WIDTH];
          ld_n     = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (ld_n) zero_n = (result_n == '0);
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: single-cycle ops, SHL/MUL latency, busy lockout,
// back-to-back streaming and asynchronous reset mid-operation.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic [7:0] result;
  logic       ld_ac, busy, zero_flag, carry_flag;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  alu_core #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .a_in(a_in), .b_in(b_in), .result(result), .ld_ac(ld_ac),
    .busy(busy), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: present a request, let one edge sample it, drop start 1ns later
  task automatic do_start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; opcode = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({result, ld_ac, busy, zero_flag, carry_flag} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h ld=%b busy=%b z=%b c=%b, want all 0",
               result, ld_ac, busy, zero_flag, carry_flag);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // single-cycle ops: {ld, result, zero, carry} one cycle after the start edge
  task automatic test_single;
    logic [2:0] ops [7] = '{3'b001, 3'b010, 3'b010, 3'b000, 3'b011, 3'b001, 3'b111};
    logic [7:0] as  [7] = '{8'hF0, 8'h05, 8'h03, 8'h11, 8'hF0, 8'hFF, 8'h77};
    logic [7:0] bs  [7] = '{8'h20, 8'h05, 8'h05, 8'h5A, 8'h3C, 8'h01, 8'h99};
    logic [10:0] exp [7] = '{{1'b1, 8'h10, 1'b0, 1'b1}, {1'b1, 8'h00, 1'b1, 1'b0},
                             {1'b1, 8'hFE, 1'b0, 1'b1}, {1'b1, 8'h5A, 1'b0, 1'b0},
                             {1'b1, 8'h30, 1'b0, 1'b0}, {1'b1, 8'h00, 1'b1, 1'b1},
                             {1'b1, 8'h77, 1'b0, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      do_start(ops[i], as[i], bs[i]);
      checks++;
      if ({ld_ac, result, zero_flag, carry_flag} !== exp[i]) begin
        errors++;
        $display("FAIL single_op%0d: got ld=%b res=%h z=%b c=%b, want %h",
                 i, ld_ac, result, zero_flag, carry_flag, exp[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (ld_ac !== 1'b0 || result !== exp[i][9:2]) begin
        errors++;
        $display("FAIL single_hold%0d: got ld=%b res=%h, want ld=0 res=%h",
                 i, ld_ac, result, exp[i][9:2]);
      end
    end
  endtask

  // multi-cycle ops: latency counted from the start edge, busy samples counted
  task automatic test_multi;
    logic [2:0] ops [5] = '{3'b101, 3'b101, 3'b101, 3'b110, 3'b110};
    logic [7:0] as  [5] = '{8'h81, 8'h81, 8'h01, 8'h0F, 8'h10};
    logic [7:0] bs  [5] = '{8'h01, 8'h00, 8'h07, 8'h11, 8'h10};
    logic [7:0] eres [5] = '{8'h02, 8'h81, 8'h80, 8'hFF, 8'h00};
    logic       ez   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ec   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int         elat [5] = '{2, 1, 8, 9, 9};
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      do_start(ops[i], as[i], bs[i]);
      lat = 1; bcnt = 0;
      while (ld_ac !== 1'b1 && lat < 20) begin
        if (busy === 1'b1) bcnt++;
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (ld_ac !== 1'b1 || lat != elat[i] || bcnt != elat[i] - 1) begin
        errors++;
        $display("FAIL multi_latency%0d: got ld=%b lat=%0d busy_cycles=%0d, want lat=%0d busy_cycles=%0d",
                 i, ld_ac, lat, bcnt, elat[i], elat[i] - 1);
      end
      checks++;
      if ({result, zero_flag, carry_flag, busy} !== {eres[i], ez[i], ec[i], 1'b0}) begin
        errors++;
        $display("FAIL multi_result%0d: got res=%h z=%b c=%b busy=%b, want res=%h z=%b c=%b busy=0",
                 i, result, zero_flag, carry_flag, busy, eres[i], ez[i], ec[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (ld_ac !== 1'b0) begin
        errors++;
        $display("FAIL multi_pulse_width%0d: got ld=%b, want 0", i, ld_ac);
      end
    end
  endtask

  task automatic test_busy_lockout;
    int pulses, pulse_at;
    logic [7:0] pres;
    do_start(3'b110, 8'h0F, 8'h11);
    @(posedge clk); #1;
    do_start(3'b001, 8'h01, 8'h01);
    pulses = 0; pulse_at = 0; pres = 8'h00;
    for (int c = 3; c < 16; c++) begin
      if (ld_ac === 1'b1) begin
        pulses++; pulse_at = c; pres = result;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 1 || pulse_at != 9 || pres !== 8'hFF) begin
      errors++;
      $display("FAIL busy_lockout: got pulses=%0d at=%0d res=%h, want pulses=1 at=9 res=ff",
               pulses, pulse_at, pres);
    end
  endtask

  task automatic test_back_to_back;
    start = 1'b1; opcode = 3'b001; a_in = 8'hFF; b_in = 8'h02;
    @(posedge clk); #1;
    checks++;
    if ({ld_ac, result, zero_flag, carry_flag} !== {1'b1, 8'h01, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_add: got ld=%b res=%h z=%b c=%b, want ld=1 res=01 z=0 c=1",
               ld_ac, result, zero_flag, carry_flag);
    end
    opcode = 3'b100; a_in = 8'h0F; b_in = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({ld_ac, result, zero_flag, carry_flag} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_xor: got ld=%b res=%h z=%b c=%b, want ld=1 res=00 z=1 c=0",
               ld_ac, result, zero_flag, carry_flag);
    end
    @(posedge clk); #1;
    checks++;
    if (ld_ac !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got ld=%b, want 0", ld_ac);
    end
  endtask

  task automatic test_reset_mid_op;
    int pulses;
    // leave a nonzero result behind so the async clear is observable
    do_start(3'b000, 8'h00, 8'hA5);
    do_start(3'b110, 8'h0F, 8'h11);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({result, ld_ac, busy, zero_flag, carry_flag} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_op: got res=%h ld=%b busy=%b z=%b c=%b, want all 0",
               result, ld_ac, busy, zero_flag, carry_flag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (ld_ac === 1'b1 || busy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: got %0d active cycles, want 0", pulses);
    end
    do_start(3'b001, 8'h12, 8'h34);
    checks++;
    if ({ld_ac, result, zero_flag, carry_flag} !== {1'b1, 8'h46, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_recover: got ld=%b res=%h z=%b c=%b, want ld=1 res=46 z=0 c=0",
               ld_ac, result, zero_flag, carry_flag);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_busy_lockout;
    test_back_to_back;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
